p2p_recv_guard: RTL and testbench

- Packet-atomic admission stage on the P2P receive path, between the vIO switch P2P output and the gateway_recv P2P input.
- Decides one allow/drop verdict per packet on its first beat and holds it until tlast.
- Allowed packets pass through a one-stage register slice. Dropped packets are drained at line rate, so a rejected sender never stalls the switch.
- Keeps per-vFPGA packet counters and records the last rejected sender for host diagnostics.

---
 rtl/p2p_recv_guard_pkg.sv | 13 +
 rtl/p2p_recv_guard_slice.sv | 63 ++++++
 rtl/p2p_recv_guard.sv | 121 ++++++++++++
 tb/tb_p2p_recv_guard.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/p2p_recv_guard_pkg.sv
// Shared definitions for the P2P receive guard: route_id sender field and guard FSM states.
package p2p_recv_guard_pkg;

  localparam int P2P_SENDER_LSB = 6;
  localparam int P2P_SENDER_MSB = 9;

  typedef enum logic [1:0] {
    SOP,
    PASS,
    DROP
  } guard_state_t;

endpackage

// File: rtl/p2p_recv_guard_slice.sv
// Single-entry valid/ready register slice carrying tdata/tkeep/tlast/tdest/tid.
module axis_reg_slice_p2p #(
  parameter int DATA_W    = 512,
  parameter int DEST_BITS = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  input  logic [DATA_W/8-1:0]    s_keep,
  input  logic                   s_last,
  input  logic [DEST_BITS-1:0]   s_dest,
  input  logic [3:0]             s_id,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic [DATA_W/8-1:0]    m_keep,
  output logic                   m_last,
  output logic [DEST_BITS-1:0]   m_dest,
  output logic [3:0]             m_id
);

  logic                 valid_q;
  logic [DATA_W-1:0]    data_q;
  logic [DATA_W/8-1:0]  keep_q;
  logic                 last_q;
  logic [DEST_BITS-1:0] dest_q;
  logic [3:0]           id_q;
  logic                 load;

  // Accept a new beat whenever the slot is empty or is being drained this cycle.
  assign s_ready = !valid_q || m_ready;
  assign load    = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      dest_q  <= '0;
      id_q    <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= s_data;
      keep_q  <= s_keep;
      last_q  <= s_last;
      dest_q  <= s_dest;
      id_q    <= s_id;
    end else if (m_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_keep  = keep_q;
  assign m_last  = last_q;
  assign m_dest  = dest_q;
  assign m_id    = id_q;

endmodule

// File: rtl/p2p_recv_guard.sv
// Packet-atomic admission guard on the P2P receive path: per-packet allow/drop,
// register-sliced pass path, line-rate drain of rejected packets, diagnostics counters.
module p2p_recv_guard
  import p2p_recv_guard_pkg::*;
#(
  parameter int ID            = 0,
  parameter int N_REGIONS     = 2,
  parameter int AXI_DATA_BITS = 512,
  parameter int DEST_BITS     = 14,
  parameter int CNT_BITS      = 32
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [13:0]                route_ctrl,
  input  logic                       guard_en,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  input  logic [AXI_DATA_BITS-1:0]   s_tdata,
  input  logic [AXI_DATA_BITS/8-1:0] s_tkeep,
  input  logic [DEST_BITS-1:0]       s_tdest,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [AXI_DATA_BITS-1:0]   m_tdata,
  output logic [AXI_DATA_BITS/8-1:0] m_tkeep,
  output logic [DEST_BITS-1:0]       m_tdest,
  output logic [3:0]                 m_tid,
  output logic [CNT_BITS-1:0]        pass_cnt,
  output logic [CNT_BITS-1:0]        drop_cnt,
  output logic                       drop_pulse,
  output logic [3:0]                 last_drop_sender
);

  localparam logic [3:0] ID_SND = 4'(ID);

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  guard_state_t        state_q, state_d;
  logic [3:0]          snd_q;
  logic [CNT_BITS-1:0] pass_cnt_q, drop_cnt_q;
  logic                drop_pulse_q;
  logic [3:0]          last_drop_q;

  logic [3:0] snd, allowed_snd, cur_snd;
  logic       allow_now, fwd, slice_ready, xfer, first_drop;
  logic       unused_route;

  assign snd          = s_tdest[P2P_SENDER_MSB:P2P_SENDER_LSB];
  assign allowed_snd  = route_ctrl[P2P_SENDER_MSB:P2P_SENDER_LSB];
  assign unused_route = ^{route_ctrl[13:10], route_ctrl[5:0]};

  assign allow_now = !guard_en ||
                     (int'(snd) < N_REGIONS && snd != ID_SND &&
                      (allowed_snd == 4'd0 || snd == allowed_snd));

  // The verdict is only live on the first beat; afterwards the FSM state is the latched verdict.
  assign fwd        = (state_q == PASS) || (state_q == SOP && allow_now);
  assign cur_snd    = (state_q == SOP) ? snd : snd_q;
  assign s_tready   = fwd ? slice_ready : 1'b1;
  assign xfer       = s_tvalid && s_tready;
  assign first_drop = xfer && (state_q == SOP) && !allow_now;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SOP:     if (xfer && !s_tlast) state_d = allow_now ? PASS : DROP;
      PASS:    if (xfer && s_tlast)  state_d = SOP;
      DROP:    if (xfer && s_tlast)  state_d = SOP;
      default: state_d = SOP;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= SOP;
      snd_q        <= '0;
      pass_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      last_drop_q  <= '0;
    end else begin
      state_q      <= state_d;
      drop_pulse_q <= first_drop;
      if (xfer && state_q == SOP) snd_q <= snd;
      if (first_drop) last_drop_q <= snd;
      if (xfer && s_tlast && fwd)  pass_cnt_q <= sat_inc(pass_cnt_q);
      if (xfer && s_tlast && !fwd) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  axis_reg_slice_p2p #(
    .DATA_W    (AXI_DATA_BITS),
    .DEST_BITS (DEST_BITS)
  ) u_slice (
    .clk     (aclk),
    .rst     (areset),
    .s_valid (s_tvalid && fwd),
    .s_ready (slice_ready),
    .s_data  (s_tdata),
    .s_keep  (s_tkeep),
    .s_last  (s_tlast),
    .s_dest  (s_tdest),
    .s_id    (cur_snd),
    .m_valid (m_tvalid),
    .m_ready (m_tready),
    .m_data  (m_tdata),
    .m_keep  (m_tkeep),
    .m_last  (m_tlast),
    .m_dest  (m_tdest),
    .m_id    (m_tid)
  );

  assign pass_cnt         = pass_cnt_q;
  assign drop_cnt         = drop_cnt_q;
  assign drop_pulse       = drop_pulse_q;
  assign last_drop_sender = last_drop_q;

endmodule

// File: tb/tb_p2p_recv_guard.sv
// Directed self-checking bench for p2p_recv_guard (ID=0, N_REGIONS=2).
module tb_p2p_recv_guard;

  logic         aclk = 1'b0;
  logic         areset;
  logic [13:0]  route_ctrl;
  logic         guard_en;
  logic         s_tvalid, s_tready, s_tlast;
  logic [511:0] s_tdata;
  logic [63:0]  s_tkeep;
  logic [13:0]  s_tdest;
  logic         m_tvalid, m_tready, m_tlast;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic [13:0]  m_tdest;
  logic [3:0]   m_tid;
  logic [31:0]  pass_cnt, drop_cnt;
  logic         drop_pulse;
  logic [3:0]   last_drop_sender;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  p2p_recv_guard #(
    .ID(0), .N_REGIONS(2), .AXI_DATA_BITS(512), .DEST_BITS(14), .CNT_BITS(32)
  ) dut (
    .aclk(aclk), .areset(areset), .route_ctrl(route_ctrl), .guard_en(guard_en),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tdest(s_tdest),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tdest(m_tdest), .m_tid(m_tid),
    .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse),
    .last_drop_sender(last_drop_sender)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge aclk);
    #1;
  endtask

  // Drive one beat and let combinational outputs settle before the next edge.
  task automatic drive(input logic [13:0] dest, input logic [31:0] data, input logic last);
    s_tvalid = 1'b1;
    s_tdest  = dest;
    s_tdata  = 512'(data);
    s_tlast  = last;
    #1;
  endtask

  task automatic idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int rx;
    logic acc_in, acc_out;

    areset = 1'b1; route_ctrl = '0; guard_en = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '1; s_tdest = '0;
    m_tready = 1'b1;
    clk1(); clk1();
    areset = 1'b0;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata[63:0], 64'd0);
    chk("rst_pass_cnt", 64'(pass_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_last_drop", 64'(last_drop_sender), 64'd0);

    // 1: allowed sender 1, 4 beats at one-cycle latency
    route_ctrl = 14'h040;
    for (int i = 0; i < 4; i++) begin
      drive(14'h040, 32'h10 + 32'(i), i == 3);
      chk("t1_s_tready", 64'(s_tready), 64'd1);
      clk1();
      chk("t1_m_tvalid", 64'(m_tvalid), 64'd1);
      chk("t1_m_tdata", m_tdata[63:0], 64'h10 + 64'(i));
      chk("t1_m_tlast", 64'(m_tlast), (i == 3) ? 64'd1 : 64'd0);
      chk("t1_m_tid", 64'(m_tid), 64'd1);
    end
    chk("t1_m_tdest", 64'(m_tdest), 64'h040);
    chk("t1_m_tkeep", m_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    chk("t1_pass_cnt", 64'(pass_cnt), 64'd1);
    chk("t1_drop_cnt", 64'(drop_cnt), 64'd0);
    clk1();
    chk("t1_m_tvalid_clear", 64'(m_tvalid), 64'd0);

    // 2: sender 3 is outside the region range, drained at line rate
    for (int i = 0; i < 3; i++) begin
      drive(14'h0C0, 32'h20 + 32'(i), i == 2);
      chk("t2_s_tready", 64'(s_tready), 64'd1);
      clk1();
      chk("t2_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("t2_drop_pulse", 64'(drop_pulse), (i == 0) ? 64'd1 : 64'd0);
    end
    idle();
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t2_last_drop", 64'(last_drop_sender), 64'd3);
    clk1();
    chk("t2_drop_pulse_idle", 64'(drop_pulse), 64'd0);

    // 3: self-loop dropped, sender == N_REGIONS dropped, guard off admits
    route_ctrl = 14'h000;
    drive(14'h000, 32'h30, 1'b1);
    chk("t3_self_s_tready", 64'(s_tready), 64'd1);
    clk1(); idle();
    chk("t3_self_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t3_self_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t3_self_pulse", 64'(drop_pulse), 64'd1);
    chk("t3_self_last_drop", 64'(last_drop_sender), 64'd0);
    clk1();
    drive(14'h080, 32'h31, 1'b1);
    clk1(); idle();
    chk("t3_nreg_drop_cnt", 64'(drop_cnt), 64'd3);
    chk("t3_nreg_last_drop", 64'(last_drop_sender), 64'd2);
    chk("t3_nreg_m_tvalid", 64'(m_tvalid), 64'd0);
    clk1();
    guard_en = 1'b0;
    drive(14'h000, 32'h32, 1'b1);
    clk1(); idle();
    chk("t3_open_m_tvalid", 64'(m_tvalid), 64'd1);
    chk("t3_open_m_tdata", m_tdata[63:0], 64'h32);
    chk("t3_open_m_tid", 64'(m_tid), 64'd0);
    chk("t3_open_pass_cnt", 64'(pass_cnt), 64'd2);
    clk1();
    guard_en = 1'b1;

    // 4: route_ctrl revoked mid-packet does not cut the packet short
    route_ctrl = 14'h040;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) route_ctrl = 14'h080;
      drive(14'h040, 32'h40 + 32'(i), i == 7);
      clk1();
      chk("t4_m_tvalid", 64'(m_tvalid), 64'd1);
      chk("t4_m_tdata", m_tdata[63:0], 64'h40 + 64'(i));
    end
    idle();
    chk("t4_pass_cnt", 64'(pass_cnt), 64'd3);
    clk1();
    drive(14'h040, 32'h48, 1'b1);
    clk1(); idle();
    chk("t4_next_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t4_next_drop_cnt", 64'(drop_cnt), 64'd4);
    clk1();

    // 5: 1010 backpressure on a 6-beat packet
    route_ctrl = 14'h040;
    b = 0; rx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      m_tready = (cyc % 2) == 0;
      if (b < 6) drive(14'h040, 32'h50 + 32'(b), b == 5);
      else begin idle(); #1; end
      if (m_tvalid && !m_tready) chk("t5_stall_s_tready", 64'(s_tready), 64'd0);
      acc_in  = s_tvalid && s_tready;
      acc_out = m_tvalid && m_tready;
      if (acc_out) begin
        chk("t5_order", m_tdata[63:0], 64'h50 + 64'(rx));
        rx++;
      end
      clk1();
      if (acc_in) b++;
    end
    idle();
    m_tready = 1'b1;
    chk("t5_rx_count", 64'(rx), 64'd6);
    chk("t5_pass_cnt", 64'(pass_cnt), 64'd4);
    clk1();

    // 6: reset after beat 2 of 5; beats 3-5 judged afresh from beat 3's tdest
    for (int i = 0; i < 2; i++) begin
      drive(14'h040, 32'h60 + 32'(i), 1'b0);
      clk1();
      chk("t6_pre_m_tdata", m_tdata[63:0], 64'h60 + 64'(i));
    end
    idle();
    areset = 1'b1;
    clk1();
    areset = 1'b0;
    chk("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_pass_cnt", 64'(pass_cnt), 64'd0);
    chk("t6_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 2; i < 5; i++) begin
      drive(14'h0C0, 32'h60 + 32'(i), i == 4);
      chk("t6_tail_s_tready", 64'(s_tready), 64'd1);
      clk1();
      chk("t6_tail_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("t6_tail_pulse", 64'(drop_pulse), (i == 2) ? 64'd1 : 64'd0);
    end
    idle();
    chk("t6_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t6_pass_cnt", 64'(pass_cnt), 64'd0);
    chk("t6_last_drop", 64'(last_drop_sender), 64'd3);
    clk1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
